// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG quantization stage.
// Holds the coefficient and index widths, the block length, the ROM value
// width, the divider remainder width and the quantizer FSM state type.
package jpeg_pkg;

  localparam int COEF_W    = 12;
  localparam int BLOCK_LEN = 64;
  localparam int IDX_W     = 6;
  localparam int Q_W       = 8;   // widest luminance step is 121
  localparam int REM_W     = 9;   // remainder is always below the divisor

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/quant_matrix_rom.sv
// Standard JPEG luminance quantization table, indexed in raster order.
// Purely combinational: q_val follows addr within the same cycle.
//   addr  : raster position 0..63 inside the 8x8 block
//   q_val : quantization step for that position
module quant_matrix_rom
  import jpeg_pkg::*;
(
  input  logic [IDX_W-1:0] addr,
  output logic [Q_W-1:0]   q_val
);

  localparam logic [Q_W-1:0] TBL [BLOCK_LEN] = '{
    8'd16, 8'd11, 8'd10, 8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98,  8'd112, 8'd100, 8'd103, 8'd99
  };

  assign q_val = TBL[addr];

endmodule

// File: rtl/jpeg_quantizer.sv
// Sequential quantizer: divides each incoming DCT coefficient by the
// luminance step of its raster position, rounding to nearest with ties
// away from zero, using a bit-serial restoring divider (one bit per cycle).
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : coefficient handshake, in_coef signed
//   out_valid/out_ready   : result handshake
//   out_coef              : signed quantized coefficient
//   out_idx / out_last    : raster index of out_coef, high at index 63
//
// state | meaning
// IDLE  | waiting for a coefficient, in_ready high
// DIV   | one restoring-division step per cycle, MSB first
// DONE  | result presented, held until out_ready
module jpeg_quantizer
  import jpeg_pkg::*;
#(
  parameter int COEF_W = jpeg_pkg::COEF_W,
  parameter int ITER   = jpeg_pkg::COEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_coef,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  localparam int CNT_W = $clog2(ITER);

  state_t state_q, state_d;

  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic [Q_W-1:0]    q;
  logic              sign_q;
  logic [COEF_W-1:0] dvd_q;
  logic [REM_W-1:0]  dvs_q;
  logic [REM_W-1:0]  rem_q;
  logic [COEF_W-1:0] quot_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [COEF_W-1:0] out_coef_q;

  logic [COEF_W-1:0] abs_coef;
  logic [COEF_W-1:0] q_half;
  logic [REM_W-1:0]  rem_sh;
  logic              q_bit;
  logic [REM_W-1:0]  rem_nx;
  logic [COEF_W-1:0] quot_nx;

  quant_matrix_rom u_rom (
    .addr  (idx_q),
    .q_val (q)
  );

  // -2048 negates to 0x800, which read as unsigned is exactly 2048.
  assign abs_coef = in_coef[COEF_W-1] ? (~in_coef + COEF_W'(1)) : in_coef;
  assign q_half   = COEF_W'(q >> 1);

  assign rem_sh  = {rem_q[REM_W-2:0], dvd_q[COEF_W-1]};
  assign q_bit   = (rem_sh >= dvs_q);
  assign rem_nx  = q_bit ? (rem_sh - dvs_q) : rem_sh;
  assign quot_nx = {quot_q[COEF_W-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = DIV;
      end
      DIV: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      out_idx_q  <= '0;
      sign_q     <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      out_coef_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q    <= in_coef[COEF_W-1];
            dvd_q     <= abs_coef + q_half;
            dvs_q     <= {{(REM_W-Q_W){1'b0}}, q};
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= CNT_W'(ITER-1);
            out_idx_q <= idx_q;
          end
        end
        DIV: begin
          dvd_q  <= dvd_q << 1;
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            // Negate only non-zero quotients so a zero never comes out as -0.
            out_coef_q <= (sign_q && (quot_nx != '0)) ? (~quot_nx + COEF_W'(1)) : quot_nx;
          end
        end
        DONE: begin
          if (out_ready) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_coef = out_coef_q;
  assign out_idx  = out_idx_q;
  assign out_last = (out_idx_q == IDX_W'(BLOCK_LEN-1));

endmodule

// File: tb/tb_jpeg_quantizer.sv
module tb_jpeg_quantizer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_coef;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coef;
  logic [5:0]  out_idx;
  logic        out_last;

  int checks;
  int errors;

  int tbl [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };

  jpeg_quantizer #(.COEF_W(12), .ITER(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int scoef();
    return int'($signed(out_coef));
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_coef   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Sends one coefficient, waits for the result, checks it and accepts it.
  // Returns the number of negedges from the accept edge to out_valid.
  task automatic run(input string tag, input int coef, input int exp_coef,
                     input int exp_idx, output int lat);
    int n;
    lat = -1;
    chk({tag, " in_ready"}, int'(in_ready), 1);
    in_coef  = 12'(coef);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      chk({tag, " timeout"}, 0, 1);
      return;
    end
    lat = n;
    chk({tag, " coef"}, scoef(), exp_coef);
    chk({tag, " idx"},  int'(out_idx), exp_idx);
    chk({tag, " last"}, int'(out_last), (exp_idx == 63) ? 1 : 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, " valid drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int lat;
    int hold_coef;
    int hold_idx;
    checks = 0;
    errors = 0;

    // Reset values
    do_reset();
    #1;
    chk("rst in_ready",  int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_coef",  int'(out_coef), 0);
    chk("rst out_idx",   int'(out_idx), 0);
    chk("rst out_last",  int'(out_last), 0);

    // Basic: (100+8)/16 = 6 ; (24+5)/11 = 2 -> -2
    run("p100", 100, 6, 0, lat);
    chk("latency", lat, 13);
    run("n24 idx1", -24, -2, 1, lat);

    // Ties away from zero: (24+8)/16 = 2
    do_reset();
    run("tie pos", 24, 2, 0, lat);
    do_reset();
    run("tie neg", -24, -2, 0, lat);
    do_reset();
    run("neg zero", -3, 0, 0, lat);

    // Extremes at q=10: (2048+5)/10 = 205, (2047+5)/10 = 205
    do_reset();
    run("adv0", 0, 0, 0, lat);
    run("adv1", 0, 0, 1, lat);
    run("min", -2048, -205, 2, lat);
    do_reset();
    run("adv0b", 0, 0, 0, lat);
    run("adv1b", 0, 0, 1, lat);
    run("max", 2047, 205, 2, lat);

    // Full block of 1000, then wrap to idx 0: (1000+8)/16 = 63
    do_reset();
    for (int i = 0; i < 64; i++) begin
      run($sformatf("blk%0d", i), 1000, (1000 + tbl[i] / 2) / tbl[i], i, lat);
    end
    run("wrap", 1000, 63, 0, lat);

    // Backpressure: (50+8)/16 = 3 held, then (50+5)/11 = 5 at idx 1
    do_reset();
    in_coef  = 12'd50;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    chk("bp valid", int'(out_valid), 1);
    hold_coef = scoef();
    hold_idx  = int'(out_idx);
    chk("bp coef", hold_coef, 3);
    in_coef  = 12'd777;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp hold valid", int'(out_valid), 1);
      chk("bp in_ready",   int'(in_ready), 0);
      chk("bp hold coef",  scoef(), 3);
      chk("bp hold idx",   int'(out_idx), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp released", int'(out_valid), 0);
    chk("bp in_ready2", int'(in_ready), 1);
    @(negedge clk);
    chk("bp single xfer", int'(out_valid), 0);
    run("bp next", 50, 5, 1, lat);

    // Reset mid-DIV with idx advanced to 3
    do_reset();
    run("r0", 0, 0, 0, lat);
    run("r1", 0, 0, 1, lat);
    run("r2", 0, 0, 2, lat);
    in_coef  = 12'd500;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", int'(out_valid), 0);
    chk("mid rst in_ready",  int'(in_ready), 1);
    chk("mid rst out_idx",   int'(out_idx), 0);
    chk("mid rst out_coef",  int'(out_coef), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("post rst", 100, 6, 0, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
